sram_write_driver: RTL

//  Write side of the mixed-signal SRAM array. Counterpart of the read-path sense amplifiers.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_write_driver_if.sv | 26 ++
 rtl/sram_phase_timer.sv | 29 ++
 rtl/sram_write_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared SRAM write-path definitions: supply levels, driver state encoding, sizing helper.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        DRIVE     = 2'd2,
        RECOVER   = 2'd3
    } wd_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_write_driver_if.sv
// Write-request handshake bundle between a requester and sram_write_driver.
// wr_mask exists only when SRAM_WRITE_MASK_EN is defined.
interface sram_write_driver_if #(
    parameter int ADDR_W = 2,
    parameter int COLS   = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [COLS-1:0]   wr_data;
    logic              wr_done;
    logic              wr_err;
`ifdef SRAM_WRITE_MASK_EN
    logic [COLS-1:0]   wr_mask;

    modport master (output wr_valid, wr_addr, wr_data, wr_mask,
                    input  wr_ready, wr_done, wr_err);
    modport slave  (input  wr_valid, wr_addr, wr_data, wr_mask,
                    output wr_ready, wr_done, wr_err);
`else
    modport master (output wr_valid, wr_addr, wr_data,
                    input  wr_ready, wr_done, wr_err);
    modport slave  (input  wr_valid, wr_addr, wr_data,
                    output wr_ready, wr_done, wr_err);
`endif
endinterface

// File: rtl/sram_phase_timer.sv
// Loadable down-counter timing the precharge and drive phases; last flags the final cycle.
module sram_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load at phase entry, then count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sram_write_driver.sv
// SRAM write driver: precharge, word-line assert and bit-line drive as real voltages.
// Optional per-column write mask enabled by SRAM_WRITE_MASK_EN.
module sram_write_driver
    import sram_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 8,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_write_driver_if.slave  wr,
    output real                 row_wr [0:ROWS-1],
    output real                 bl_wr  [0:ROWS-1][0:COLS-1],
    output real                 blb_wr [0:ROWS-1][0:COLS-1]
);

    localparam int ADDR_W = $clog2(ROWS);
    localparam int CNT_W  = $clog2(max_int(PRE_CYC, WL_CYC) + 1);

    wd_state_t         state_r, state_nx_s;
    logic [ADDR_W-1:0] addr_r, addr_nx_s;
    logic [COLS-1:0]   data_r, data_nx_s;
    logic [COLS-1:0]   mask_nx_s;
    logic              accept_s;
    logic              tmr_load_s;
    logic [CNT_W-1:0]  tmr_val_s;
    logic              tmr_last_s;

    logic              ready_r, done_r, err_r;
    logic [ROWS-1:0]   wl_r, wl_nx_s;
    logic [COLS-1:0]   bl_r  [ROWS];
    logic [COLS-1:0]   blb_r [ROWS];
    logic [COLS-1:0]   bl_nx_s  [ROWS];
    logic [COLS-1:0]   blb_nx_s [ROWS];

    assign accept_s = ready_r && wr.wr_valid;

    sram_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .last     (tmr_last_s)
    );

    // Next-state logic; the timer is loaded on the transition into each timed phase.
    always_comb begin
        state_nx_s = state_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = PRECHARGE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(PRE_CYC);
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PRECHARGE: begin
                if (tmr_last_s) begin
                    state_nx_s = DRIVE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = CNT_W'(WL_CYC);
                end else begin
                    state_nx_s = PRECHARGE;
                end
            end
            DRIVE: begin
                if (tmr_last_s) begin
                    state_nx_s = RECOVER;
                end else begin
                    state_nx_s = DRIVE;
                end
            end
            RECOVER: state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Request capture mux: the incoming request is used in its own accept cycle.
    always_comb begin
        if (accept_s) begin
            addr_nx_s = wr.wr_addr;
            data_nx_s = wr.wr_data;
        end else begin
            addr_nx_s = addr_r;
            data_nx_s = data_r;
        end
    end

`ifdef SRAM_WRITE_MASK_EN
    logic [COLS-1:0] mask_r;

    // Mask capture mux alongside the data word.
    always_comb begin
        if (accept_s) begin
            mask_nx_s = wr.wr_mask;
        end else begin
            mask_nx_s = mask_r;
        end
    end

    // Mask latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= '0;
        end else begin
            mask_r <= mask_nx_s;
        end
    end
`else
    assign mask_nx_s = '1;
`endif

    // Line enables for the upcoming cycle; an out-of-range row matches no r and stays dark.
    always_comb begin
        wl_nx_s  = '0;
        bl_nx_s  = '{default: '0};
        blb_nx_s = '{default: '0};
        for (int r = 0; r < ROWS; r++) begin
            if (int'(addr_nx_s) == r) begin
                case (state_nx_s)
                    PRECHARGE, RECOVER: begin
                        bl_nx_s[r]  = '1;
                        blb_nx_s[r] = '1;
                    end
                    DRIVE: begin
                        wl_nx_s[r]  = 1'b1;
                        bl_nx_s[r]  = data_nx_s | ~mask_nx_s;
                        blb_nx_s[r] = ~data_nx_s | ~mask_nx_s;
                    end
                    default: begin
                        bl_nx_s[r]  = '0;
                        blb_nx_s[r] = '0;
                    end
                endcase
            end else begin
                bl_nx_s[r]  = '0;
                blb_nx_s[r] = '0;
            end
        end
    end

    // State, request latch and registered handshake/line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            addr_r  <= '0;
            data_r  <= '0;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            wl_r    <= '0;
            bl_r    <= '{default: '0};
            blb_r   <= '{default: '0};
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            data_r  <= data_nx_s;
            ready_r <= (state_nx_s == IDLE);
            done_r  <= (state_nx_s == RECOVER);
            err_r   <= (state_nx_s == RECOVER) && (int'(addr_nx_s) >= ROWS);
            wl_r    <= wl_nx_s;
            bl_r    <= bl_nx_s;
            blb_r   <= blb_nx_s;
        end
    end

    assign wr.wr_ready = ready_r;
    assign wr.wr_done  = done_r;
    assign wr.wr_err   = err_r;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_wr[r] = wl_r[r] ? VDD : VSS;
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign bl_wr[r][c]  = bl_r[r][c]  ? VDD : VSS;
            assign blb_wr[r][c] = blb_r[r][c] ? VDD : VSS;
        end
    end

endmodule
